mem_region_ctrl: RTL and testbench

Parametrised successor to the single-port core memory controller: arbitrates the core's memory/IO accesses with a request/acknowledge handshake. Decodes a configurable region map (TEXT, GLYPH, INSTR, INPUT, OUTPUT, STACK) and drives the shared true-dual-port BRAM. Serves NUM_IN input channels with programmable wait states and NUM_OUT registered output channels. Sits between the CPU core and the BRAM/VGA/IO fabric; VGA keeps BRAM port A as a read-only passthrough.

---
 rtl/mem_ctrl_pkg.sv | 36 +++
 rtl/mem_region_decode.sv | 68 ++++++
 rtl/mem_region_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_region_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default region map for the memory/IO region controller.
// Regions are packed contiguously from address 0 in enum order.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_TEXT,
    REG_GLYPH,
    REG_INSTR,
    REG_INPUT,
    REG_OUTPUT,
    REG_STACK
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    IO_WAIT_ST,
    RESP
  } state_t;

  localparam int unsigned DEF_SIZE_TEXT   = 8192;
  localparam int unsigned DEF_SIZE_GLYPH  = 1024;
  localparam int unsigned DEF_SIZE_INSTR  = 10240;
  localparam int unsigned DEF_SIZE_INPUT  = 512;
  localparam int unsigned DEF_SIZE_OUTPUT = 512;
  localparam int unsigned DEF_SIZE_STACK  = 10240;

  localparam int unsigned DEF_BASE_TEXT   = 0;
  localparam int unsigned DEF_BASE_GLYPH  = DEF_BASE_TEXT + DEF_SIZE_TEXT;
  localparam int unsigned DEF_BASE_INSTR  = DEF_BASE_GLYPH + DEF_SIZE_GLYPH;
  localparam int unsigned DEF_BASE_INPUT  = DEF_BASE_INSTR + DEF_SIZE_INSTR;
  localparam int unsigned DEF_BASE_OUTPUT = DEF_BASE_INPUT + DEF_SIZE_INPUT;
  localparam int unsigned DEF_BASE_STACK  = DEF_BASE_OUTPUT + DEF_SIZE_OUTPUT;
  localparam int unsigned DEF_END_STACK   = DEF_BASE_STACK + DEF_SIZE_STACK;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: word address -> region, channel indices, in-map flag.
// Addresses past the end of STACK report region STACK with in_map low.
module mem_region_decode
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W                = 15,
  parameter int unsigned SIZE_TEXT    = DEF_SIZE_TEXT,
  parameter int unsigned SIZE_GLYPH   = DEF_SIZE_GLYPH,
  parameter int unsigned SIZE_INSTR   = DEF_SIZE_INSTR,
  parameter int unsigned SIZE_INPUT   = DEF_SIZE_INPUT,
  parameter int unsigned SIZE_OUTPUT  = DEF_SIZE_OUTPUT,
  parameter int unsigned SIZE_STACK   = DEF_SIZE_STACK,
  parameter int NUM_IN                = 2,
  parameter int NUM_OUT               = 2,
  parameter int IN_W                  = 1,
  parameter int OUT_W                 = 1
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [IN_W-1:0]   in_ch,
  output logic [OUT_W-1:0]  out_ch,
  output logic              in_map
);

  localparam logic [31:0] BASE_TEXT   = 32'd0;
  localparam logic [31:0] BASE_GLYPH  = BASE_TEXT + 32'(SIZE_TEXT);
  localparam logic [31:0] BASE_INSTR  = BASE_GLYPH + 32'(SIZE_GLYPH);
  localparam logic [31:0] BASE_INPUT  = BASE_INSTR + 32'(SIZE_INSTR);
  localparam logic [31:0] BASE_OUTPUT = BASE_INPUT + 32'(SIZE_INPUT);
  localparam logic [31:0] BASE_STACK  = BASE_OUTPUT + 32'(SIZE_OUTPUT);
  localparam logic [31:0] END_STACK   = BASE_STACK + 32'(SIZE_STACK);

  logic [31:0] addr_ext;
  logic [31:0] base;
  logic [31:0] offset;

  assign addr_ext = 32'(addr);
  assign offset   = addr_ext - base;

  // Strict '<' against the next base lets zero-sized regions fall through.
  always_comb begin
    region = REG_STACK;
    base   = BASE_STACK;
    in_map = (addr_ext < END_STACK);
    if (addr_ext < BASE_GLYPH) begin
      region = REG_TEXT;
      base   = BASE_TEXT;
    end else if (addr_ext < BASE_INSTR) begin
      region = REG_GLYPH;
      base   = BASE_GLYPH;
    end else if (addr_ext < BASE_INPUT) begin
      region = REG_INSTR;
      base   = BASE_INSTR;
    end else if (addr_ext < BASE_OUTPUT) begin
      region = REG_INPUT;
      base   = BASE_INPUT;
    end else if (addr_ext < BASE_STACK) begin
      region = REG_OUTPUT;
      base   = BASE_OUTPUT;
    end
  end

  always_comb begin
    in_ch  = IN_W'(offset % 32'(NUM_IN));
    out_ch = OUT_W'(offset % 32'(NUM_OUT));
  end

endmodule

// File: rtl/mem_region_ctrl.sv
// Core memory/IO controller: region decode, BRAM port B, input/output channels.
// Optional macro MEM_REGION_CTRL_BOUNDS_EN turns out-of-map accesses into error acks.
module mem_region_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W                = 16,
  parameter int ADDR_W                = 15,
  parameter int unsigned SIZE_TEXT    = DEF_SIZE_TEXT,
  parameter int unsigned SIZE_GLYPH   = DEF_SIZE_GLYPH,
  parameter int unsigned SIZE_INSTR   = DEF_SIZE_INSTR,
  parameter int unsigned SIZE_INPUT   = DEF_SIZE_INPUT,
  parameter int unsigned SIZE_OUTPUT  = DEF_SIZE_OUTPUT,
  parameter int unsigned SIZE_STACK   = DEF_SIZE_STACK,
  parameter int NUM_IN                = 2,
  parameter int NUM_OUT               = 2,
  parameter int IO_WAIT               = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_req,
  input  logic                      core_we,
  input  logic [ADDR_W-1:0]         core_addr,
  input  logic [DATA_W-1:0]         core_wdata,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      core_ack,
  output logic                      core_err,
  input  logic [ADDR_W-1:0]         vga_addr,
  output logic [DATA_W-1:0]         vga_data_out,
  output logic [ADDR_W-1:0]         mem_addra,
  input  logic [DATA_W-1:0]         mem_douta,
  output logic                      mem_web,
  output logic [ADDR_W-1:0]         mem_addrb,
  output logic [DATA_W-1:0]         mem_dinb,
  input  logic [DATA_W-1:0]         mem_doutb,
  input  logic [NUM_IN*DATA_W-1:0]  io_data_in,
  output logic [NUM_IN-1:0]         io_rd_strobe,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  output state_t                    fsm_state
);

  localparam int IN_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int OUT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(IO_WAIT);

`ifdef MEM_REGION_CTRL_BOUNDS_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  // Handshake: core_req is sampled only in IDLE and must hold addr/we/wdata
  // stable until core_ack; core_ack (and core_err) pulse for exactly one cycle.

  region_t            region;
  logic [IN_W-1:0]    in_ch, in_ch_q;
  logic [OUT_W-1:0]   out_ch, out_ch_q;
  logic               in_map, oob, is_mem, accept;
  state_t             state, state_next;
  logic [3:0]         wait_cnt;
  logic               rd_out_q, err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  out_regs [NUM_OUT];
  logic [DATA_W-1:0]  in_words [NUM_IN];
  logic [NUM_OUT-1:0] out_valid_q;
  logic [NUM_IN-1:0]  strobe_q;

  mem_region_decode #(
    .ADDR_W(ADDR_W), .SIZE_TEXT(SIZE_TEXT), .SIZE_GLYPH(SIZE_GLYPH),
    .SIZE_INSTR(SIZE_INSTR), .SIZE_INPUT(SIZE_INPUT), .SIZE_OUTPUT(SIZE_OUTPUT),
    .SIZE_STACK(SIZE_STACK), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT),
    .IN_W(IN_W), .OUT_W(OUT_W)
  ) u_decode (
    .addr(core_addr), .region(region), .in_ch(in_ch), .out_ch(out_ch), .in_map(in_map)
  );

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_data[k*DATA_W +: DATA_W] = out_regs[k];
  end
  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    assign in_words[k] = io_data_in[k*DATA_W +: DATA_W];
  end

  assign oob    = BOUNDS_ON && !in_map;
  assign is_mem = (region == REG_TEXT) || (region == REG_GLYPH) ||
                  (region == REG_INSTR) || (region == REG_STACK);
  assign accept = (state == IDLE) && core_req;

  // Port A belongs to VGA and bypasses the FSM entirely.
  assign mem_addra    = vga_addr;
  assign vga_data_out = mem_douta;

  assign mem_addrb    = core_addr;
  assign mem_dinb     = core_wdata;
  assign mem_web      = !reset && accept && core_we && is_mem && !oob;
  assign core_ack     = (state == RESP);
  assign core_err     = BOUNDS_ON && (state == RESP) && err_q;
  assign core_rdata   = rdata_q;
  assign io_rd_strobe = strobe_q;
  assign out_valid    = out_valid_q;
  assign fsm_state    = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (core_req) begin
          if (oob || core_we)          state_next = RESP;
          else if (region == REG_INPUT) state_next = IO_WAIT_ST;
          else                          state_next = MEM_RD;
        end
      end
      MEM_RD:     state_next = RESP;
      IO_WAIT_ST: if (wait_cnt == 4'd0) state_next = RESP;
      RESP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      rd_out_q    <= 1'b0;
      err_q       <= 1'b0;
      in_ch_q     <= '0;
      out_ch_q    <= '0;
      rdata_q     <= '0;
      out_valid_q <= '0;
      strobe_q    <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_regs[k] <= '0;
    end else begin
      state       <= state_next;
      out_valid_q <= '0;
      strobe_q    <= '0;
      case (state)
        IDLE: begin
          if (core_req) begin
            err_q    <= oob;
            rd_out_q <= (region == REG_OUTPUT);
            in_ch_q  <= in_ch;
            out_ch_q <= out_ch;
            if (state_next == IO_WAIT_ST) wait_cnt <= WAIT_INIT;
            if (oob) begin
              rdata_q <= '0;
            end else if (core_we && region == REG_OUTPUT) begin
              out_regs[out_ch]    <= core_wdata;
              out_valid_q[out_ch] <= 1'b1;
            end
          end
        end
        MEM_RD: rdata_q <= rd_out_q ? out_regs[out_ch_q] : mem_doutb;
        IO_WAIT_ST: begin
          if (wait_cnt == 4'd0) begin
            rdata_q           <= in_words[in_ch_q];
            strobe_q[in_ch_q] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Directed bench for mem_region_ctrl with a read-first BRAM model (IO_WAIT=3).
// Default map: TEXT 0x0000, GLYPH 0x2000, INSTR 0x2400, INPUT 0x4C00, OUTPUT 0x4E00, STACK 0x5000..0x77FF.
module tb_mem_region_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [14:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic [15:0] core_rdata;
  logic        core_ack, core_err;
  logic [14:0] vga_addr = '0;
  logic [15:0] vga_data_out;
  logic [14:0] mem_addra, mem_addrb;
  logic [15:0] mem_douta, mem_doutb, mem_dinb;
  logic        mem_web;
  logic [31:0] io_data_in = {16'h00A5, 16'h005A};
  logic [1:0]  io_rd_strobe, out_valid;
  logic [31:0] out_data;
  state_t      fsm_state;

  mem_region_ctrl #(.IO_WAIT(3)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_ack(core_ack), .core_err(core_err), .vga_addr(vga_addr),
    .vga_data_out(vga_data_out), .mem_addra(mem_addra), .mem_douta(mem_douta),
    .mem_web(mem_web), .mem_addrb(mem_addrb), .mem_dinb(mem_dinb),
    .mem_doutb(mem_doutb), .io_data_in(io_data_in), .io_rd_strobe(io_rd_strobe),
    .out_data(out_data), .out_valid(out_valid), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // BRAM model: read-first on both ports, plus a bench-only preload write path.
  logic [15:0] bram [0:32767];
  logic        poke_we = 1'b0;
  logic [14:0] poke_addr = '0;
  logic [15:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_we) bram[poke_addr] <= poke_data;
    else if (mem_web) bram[mem_addrb] <= mem_dinb;
    mem_doutb <= bram[mem_addrb];
    mem_douta <= bram[mem_addra];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_we = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_we = 1'b0;
  endtask

  int          lat, web_cnt, strobe_cnt, valid_cnt;
  logic [1:0]  strobe_val, valid_val;
  logic [15:0] got_rdata;
  logic        got_err, timed_out, tail_busy;

  task automatic access(input logic we, input logic [14:0] a, input logic [15:0] d);
    int cyc;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    lat = 0; web_cnt = 0; strobe_cnt = 0; valid_cnt = 0;
    strobe_val = '0; valid_val = '0; got_err = 1'b0; timed_out = 1'b0; got_rdata = '0;
    #1;
    if (mem_web) web_cnt++;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1; cyc++;
      if (mem_web) web_cnt++;
      if (io_rd_strobe != 0) begin strobe_cnt++; strobe_val = io_rd_strobe; end
      if (out_valid != 0) begin valid_cnt++; valid_val = out_valid; end
      if (core_ack) begin lat = cyc; got_err = core_err; got_rdata = core_rdata; break; end
      if (cyc >= 40) begin timed_out = 1'b1; break; end
    end
    core_req = 1'b0;
    @(posedge clk); #1;
    tail_busy = core_ack | core_err | mem_web | (|io_rd_strobe) | (|out_valid);
    check_eq("timeout", 32'(timed_out), 32'd0);
    check_eq("pulse_tail", 32'(tail_busy), 32'd0);
  endtask

  task automatic read_expect(input string tag, input logic [14:0] a, input int exp_lat);
    logic [15:0] e;
    access(1'b0, a, 16'h0);
    e = exp_q.pop_front();
    check_eq({tag, "_rdata"}, 32'(got_rdata), 32'(e));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_web"}, 32'(web_cnt), 32'd0);
  endtask

  initial begin
    poke(15'h0000, 16'h1234);
    poke(15'h2000, 16'h2222);
    poke(15'h4BFF, 16'h3333);
    poke(15'h7FFF, 16'h7777);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(core_ack), 32'd0);
    check_eq("rst_err", 32'(core_err), 32'd0);
    check_eq("rst_rdata", 32'(core_rdata), 32'd0);
    check_eq("rst_web", 32'(mem_web), 32'd0);
    check_eq("rst_strobe", 32'(io_rd_strobe), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", out_data, 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk); reset = 1'b0;

    // Memory reads across TEXT, GLYPH and the last INSTR word.
    exp_q.push_back(16'h1234); read_expect("rd_text", 15'h0000, 2);
    exp_q.push_back(16'h2222); read_expect("rd_glyph", 15'h2000, 2);
    exp_q.push_back(16'h3333); read_expect("rd_instr_end", 15'h4BFF, 2);

    // STACK writes and read-back.
    access(1'b1, 15'h5000, 16'hBEEF);
    check_eq("wr_stack_lat", 32'(lat), 32'd1);
    check_eq("wr_stack_web", 32'(web_cnt), 32'd1);
    check_eq("wr_stack_err", 32'(got_err), 32'd0);
    exp_q.push_back(16'hBEEF); read_expect("rb_stack", 15'h5000, 2);
    access(1'b1, 15'h6C00, 16'h1111);
    check_eq("wr_6c00_web", 32'(web_cnt), 32'd1);
    exp_q.push_back(16'h1111); read_expect("rb_6c00", 15'h6C00, 2);

    // INPUT reads: IO_WAIT=3 gives ack at +5.
    access(1'b0, 15'h4C01, 16'h0);
    check_eq("in1_lat", 32'(lat), 32'd5);
    check_eq("in1_rdata", 32'(got_rdata), 32'h00A5);
    check_eq("in1_strobe", 32'(strobe_val), 32'b10);
    check_eq("in1_strobe_cnt", 32'(strobe_cnt), 32'd1);
    access(1'b0, 15'h4C02, 16'h0);
    check_eq("in0_rdata", 32'(got_rdata), 32'h005A);
    check_eq("in0_strobe", 32'(strobe_val), 32'b01);
    access(1'b1, 15'h4C00, 16'hDEAD);
    check_eq("in_wr_lat", 32'(lat), 32'd1);
    check_eq("in_wr_web", 32'(web_cnt), 32'd0);
    check_eq("in_wr_strobe", 32'(strobe_cnt), 32'd0);

    // OUTPUT channels: base+3 wraps to ch1.
    access(1'b1, 15'h4E03, 16'h0055);
    check_eq("out1_lat", 32'(lat), 32'd1);
    check_eq("out1_data", out_data, 32'h0055_0000);
    check_eq("out1_valid", 32'(valid_val), 32'b10);
    check_eq("out1_valid_cnt", 32'(valid_cnt), 32'd1);
    check_eq("out1_web", 32'(web_cnt), 32'd0);
    access(1'b1, 15'h4E00, 16'hCAFE);
    check_eq("out0_data", out_data, 32'h0055_CAFE);
    check_eq("out0_valid", 32'(valid_val), 32'b01);
    exp_q.push_back(16'h0055); read_expect("out_rb", 15'h4E01, 2);

    // Reset while waiting on an INPUT read.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 15'h4C01;
    @(posedge clk); #1;
    check_eq("wait_state", 32'(fsm_state), 32'(IO_WAIT_ST));
    @(negedge clk); reset = 1'b1; core_req = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_state", 32'(fsm_state), 32'(IDLE));
    check_eq("abort_ack", 32'(core_ack), 32'd0);
    check_eq("abort_strobe", 32'(io_rd_strobe), 32'd0);
    check_eq("abort_out", out_data, 32'd0);
    check_eq("abort_rdata", 32'(core_rdata), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("abort_no_ack", 32'(core_ack | (|io_rd_strobe)), 32'd0);
    end
    exp_q.push_back(16'h1234); read_expect("post_rst", 15'h0000, 2);

    // Out-of-map accesses.
`ifdef MEM_REGION_CTRL_BOUNDS_EN
    access(1'b0, 15'h7FFF, 16'h0);
    check_eq("oob_lat", 32'(lat), 32'd1);
    check_eq("oob_rdata", 32'(got_rdata), 32'd0);
    check_eq("oob_err", 32'(got_err), 32'd1);
    access(1'b1, 15'h7FFE, 16'h0102);
    check_eq("oob_wr_web", 32'(web_cnt), 32'd0);
    check_eq("oob_wr_err", 32'(got_err), 32'd1);
`else
    exp_q.push_back(16'h7777); read_expect("oob_rd", 15'h7FFF, 2);
    check_eq("oob_err", 32'(got_err), 32'd0);
    access(1'b1, 15'h7FFE, 16'h0102);
    check_eq("oob_wr_web", 32'(web_cnt), 32'd1);
    check_eq("oob_wr_mem", 32'(bram[15'h7FFE]), 32'h0102);
`endif

    // VGA passthrough on port A.
    @(negedge clk); vga_addr = 15'h4BFF;
    #1 check_eq("vga_addr", 32'(mem_addra), 32'h4BFF);
    @(negedge clk);
    check_eq("vga_data", 32'(vga_data_out), 32'h3333);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timed out");
  end

endmodule
